// File: rtl/vec_csr_regfile.sv
// Vector configuration CSRs: decodes vset{i}vl{i} operands, computes VLMAX
// and the new vl, and holds vl / vtype / vstart plus the rd writeback pulse.
module vec_csr_regfile #(
  parameter int XLEN = 32,
  parameter int VLEN = 512,
  parameter int ELEN = 32
) (
  input  logic            clk,
  input  logic            n_reset,
  input  logic            inst_valid,
  input  logic [XLEN-1:0] vec_inst,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            csrwr_en,
  input  logic            vl_sel,
  input  logic            vtype_sel,
  input  logic            rs1rd_de,
  output logic [XLEN-1:0] csr_vl,
  output logic [XLEN-1:0] csr_vtype,
  output logic [XLEN-1:0] csr_vstart,
  output logic [XLEN-1:0] vlmax,
  output logic            rd_wr_en,
  output logic [XLEN-1:0] rd_wdata,
  output logic [4:0]      rd_addr_o
);

  localparam int VLEN_LG = $clog2(VLEN);
  localparam int ELEN_LG = $clog2(ELEN);

  logic [XLEN-1:0] r_vl;
  logic [XLEN-1:0] r_vtype;
  logic [XLEN-1:0] r_vstart;
  logic [XLEN-1:0] r_vlmax;
  logic            r_rd_wr_en;
  logic [XLEN-1:0] r_rd_wdata;
  logic [4:0]      r_rd_addr;

  logic            w_upd;
  logic [XLEN-1:0] w_cand;
  logic [2:0]      w_lmul;
  logic [2:0]      w_sew;
  logic [3:0]      w_sew_lg;
  logic [3:0]      w_fshift;
  logic            w_frac;
  logic            w_vill;
  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_vlmax;
  logic [XLEN-1:0] w_avl;
  logic [XLEN-1:0] w_new_vl;
  logic [XLEN-1:0] w_new_vtype;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rd;
  logic            w_unused_ok;

  assign w_upd    = inst_valid & csrwr_en;
  assign w_rs1    = vec_inst[19:15];
  assign w_rd     = vec_inst[11:7];
  assign w_cand   = vtype_sel ?
                    {{(XLEN-10){1'b0}}, vec_inst[29:20]} : rs2_data;
  assign w_lmul   = w_cand[2:0];
  assign w_sew    = w_cand[5:3];
  assign w_sew_lg = {1'b0, w_sew} + 4'd3;
  assign w_frac   = w_lmul[2] & (w_lmul != 3'b100);
  assign w_fshift = 4'd8 - {1'b0, w_lmul};

  // SEW > ELEN*LMUL for fractional LMUL is a log2 compare:
  // sew_lg + (8 - vlmul) > elen_lg.
  always_comb begin
    w_vill = 1'b0;
    if (w_lmul == 3'b100)
      w_vill = 1'b1;
    if (w_sew_lg > 4'(ELEN_LG))
      w_vill = 1'b1;
    if (w_frac &&
        ({1'b0, w_sew_lg} + {1'b0, w_fshift} > 5'(ELEN_LG)))
      w_vill = 1'b1;
    if (!vtype_sel && (|rs2_data[XLEN-2:8]))
      w_vill = 1'b1;
  end

  assign w_base = XLEN'(VLEN) >> w_sew_lg;

  always_comb begin
    w_vlmax = '0;
    if (!w_vill)
      w_vlmax = w_frac ? (w_base >> w_fshift) : (w_base << w_lmul);
  end

  always_comb begin
    w_avl = r_vl;
    if (vl_sel)
      w_avl = {{(XLEN-5){1'b0}}, w_rs1};
    else if (rs1rd_de)
      w_avl = (w_rs1 != 5'd0) ? rs1_data : '1;
  end

  always_comb begin
    w_new_vl    = '0;
    w_new_vtype = {1'b1, {(XLEN-1){1'b0}}};
    if (!w_vill) begin
      w_new_vl    = (w_avl < w_vlmax) ? w_avl : w_vlmax;
      w_new_vtype = {1'b0, w_cand[XLEN-2:0]};
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_vl       <= '0;
      r_vtype    <= {1'b1, {(XLEN-1){1'b0}}};
      r_vstart   <= '0;
      r_vlmax    <= '0;
      r_rd_wr_en <= 1'b0;
      r_rd_wdata <= '0;
      r_rd_addr  <= '0;
    end else begin
      r_rd_wr_en <= w_upd & (w_rd != 5'd0);
      if (w_upd) begin
        r_vl       <= w_new_vl;
        r_vtype    <= w_new_vtype;
        r_vstart   <= '0;
        r_vlmax    <= w_vlmax;
        r_rd_wdata <= w_new_vl;
        r_rd_addr  <= w_rd;
      end
    end
  end

  assign csr_vl     = r_vl;
  assign csr_vtype  = r_vtype;
  assign csr_vstart = r_vstart;
  assign vlmax      = r_vlmax;
  assign rd_wr_en   = r_rd_wr_en;
  assign rd_wdata   = r_rd_wdata;
  assign rd_addr_o  = r_rd_addr;

  assign w_unused_ok = ^{vec_inst[XLEN-1:30], vec_inst[14:12],
                         vec_inst[6:0], rs2_data[XLEN-1]};

endmodule

// File: tb/tb_vec_csr_regfile.sv
// Directed bench for vec_csr_regfile: hand-derived CSR values plus a
// writeback scoreboard queue.
module tb_vec_csr_regfile;

  logic        clk;
  logic        n_reset;
  logic        inst_valid;
  logic [31:0] vec_inst;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        csrwr_en;
  logic        vl_sel;
  logic        vtype_sel;
  logic        rs1rd_de;
  logic [31:0] csr_vl;
  logic [31:0] csr_vtype;
  logic [31:0] csr_vstart;
  logic [31:0] vlmax;
  logic        rd_wr_en;
  logic [31:0] rd_wdata;
  logic [4:0]  rd_addr_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  addr;
  } wb_t;
  wb_t wbq[$];

  vec_csr_regfile #(.XLEN(32), .VLEN(512), .ELEN(32)) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .inst_valid (inst_valid),
    .vec_inst   (vec_inst),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .csrwr_en   (csrwr_en),
    .vl_sel     (vl_sel),
    .vtype_sel  (vtype_sel),
    .rs1rd_de   (rs1rd_de),
    .csr_vl     (csr_vl),
    .csr_vtype  (csr_vtype),
    .csr_vstart (csr_vstart),
    .vlmax      (vlmax),
    .rd_wr_en   (rd_wr_en),
    .rd_wdata   (rd_wdata),
    .rd_addr_o  (rd_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [9:0] zimm,
                                     input logic [4:0] rs1,
                                     input logic [4:0] rd);
    return {2'b00, zimm, rs1, 3'b111, rd, 7'h57};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [31:0] inst,
                     input logic [31:0] r1, input logic [31:0] r2,
                     input logic vls, input logic vts, input logic de,
                     input logic [31:0] exp_vl);
    inst_valid = v;
    csrwr_en   = 1'b1;
    vec_inst   = inst;
    rs1_data   = r1;
    rs2_data   = r2;
    vl_sel     = vls;
    vtype_sel  = vts;
    rs1rd_de   = de;
    if (v && inst[11:7] != 5'd0)
      wbq.push_back('{data: exp_vl, addr: inst[11:7]});
  endtask

  task automatic idle();
    inst_valid = 1'b0;
    csrwr_en   = 1'b0;
  endtask

  task automatic chk_wb(input string tag);
    wb_t e;
    if (rd_wr_en) begin
      if (wbq.size() == 0) begin
        chk({tag, "_wb_spurious"}, {31'd0, rd_wr_en}, 32'd0);
      end else begin
        e = wbq.pop_front();
        chk({tag, "_wdata"}, rd_wdata, e.data);
        chk({tag, "_waddr"}, {27'd0, rd_addr_o}, {27'd0, e.addr});
      end
    end else if (wbq.size() != 0) begin
      void'(wbq.pop_front());
      chk({tag, "_wb_missing"}, {31'd0, rd_wr_en}, 32'd1);
    end
  endtask

  task automatic chk_st(input string tag, input logic [31:0] vl,
                        input logic [31:0] vt, input logic [31:0] vm);
    chk({tag, "_vl"}, csr_vl, vl);
    chk({tag, "_vtype"}, csr_vtype, vt);
    chk({tag, "_vlmax"}, vlmax, vm);
  endtask

  task automatic upd(input string tag, input logic v,
                     input logic [31:0] inst, input logic [31:0] r1,
                     input logic [31:0] r2, input logic vls,
                     input logic vts, input logic de,
                     input logic [31:0] vl, input logic [31:0] vt,
                     input logic [31:0] vm);
    drv(v, inst, r1, r2, vls, vts, de, vl);
    @(negedge clk);
    idle();
    chk_wb(tag);
    chk_st(tag, vl, vt, vm);
    @(negedge clk);
    chk({tag, "_pulse_end"}, {31'd0, rd_wr_en}, 32'd0);
  endtask

  initial begin
    n_reset  = 1'b1;
    vec_inst = '0;
    rs1_data = '0;
    rs2_data = '0;
    vl_sel   = 1'b0;
    vtype_sel = 1'b0;
    rs1rd_de = 1'b0;
    idle();
    #1 n_reset = 1'b0;
    #1;
    chk_st("rst", 32'd0, 32'h8000_0000, 32'd0);
    chk("rst_vstart", csr_vstart, 32'd0);
    chk("rst_wr_en", {31'd0, rd_wr_en}, 32'd0);
    chk("rst_wdata", rd_wdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);

    upd("vsetvli_e32m1", 1, mk(10'h010, 5'd5, 5'd6), 32'd100, 0,
        0, 1, 1, 32'd16, 32'h10, 32'd16);
    chk("vstart0", csr_vstart, 32'd0);
    upd("vsetivli_e8m2", 1, mk(10'h001, 5'd5, 5'd7), 32'd77, 0,
        1, 1, 1, 32'd5, 32'h1, 32'd128);
    upd("vsetvl_e64", 1, mk(10'h000, 5'd0, 5'd8), 32'd50, 32'h18,
        0, 0, 1, 32'd0, 32'h8000_0000, 32'd0);
    upd("vsetivli_again", 1, mk(10'h001, 5'd5, 5'd7), 32'd0, 0,
        1, 1, 1, 32'd5, 32'h1, 32'd128);
    upd("keep_vl_e16", 1, mk(10'h008, 5'd0, 5'd0), 32'd999, 0,
        0, 1, 0, 32'd5, 32'h8, 32'd32);
    upd("x0_avl_e8m8", 1, mk(10'h003, 5'd0, 5'd10), 32'd3, 0,
        0, 1, 1, 32'd512, 32'h3, 32'd512);
    upd("e16mf2_ta_ma", 1, mk(10'h0CF, 5'd12, 5'd11), 32'd1000, 0,
        0, 1, 1, 32'd16, 32'hCF, 32'd16);
    upd("e32mf2_vill", 1, mk(10'h017, 5'd12, 5'd12), 32'd4, 0,
        0, 1, 1, 32'd0, 32'h8000_0000, 32'd0);
    upd("e8mf8_vill", 1, mk(10'h005, 5'd12, 5'd0), 32'd4, 0,
        0, 1, 1, 32'd0, 32'h8000_0000, 32'd0);
    upd("lmul4_vill", 1, mk(10'h004, 5'd12, 5'd13), 32'd4, 0,
        0, 1, 1, 32'd0, 32'h8000_0000, 32'd0);
    upd("rs2_hi_vill", 1, mk(10'h000, 5'd3, 5'd14), 32'd7, 32'h100,
        0, 0, 1, 32'd0, 32'h8000_0000, 32'd0);
    upd("rs2_bit31", 1, mk(10'h000, 5'd3, 5'd14), 32'd7,
        32'h8000_0010, 0, 0, 1, 32'd7, 32'h10, 32'd16);
    upd("no_valid", 0, mk(10'h001, 5'd9, 5'd7), 32'd0, 0,
        1, 1, 1, 32'd7, 32'h10, 32'd16);

    drv(1, mk(10'h000, 5'd1, 5'd15), 32'd40, 0, 0, 1, 1, 32'd40);
    @(negedge clk);
    chk_wb("b2b_1");
    chk_st("b2b_1", 32'd40, 32'h0, 32'd64);
    drv(1, mk(10'h008, 5'd0, 5'd16), 32'd1, 0, 0, 1, 0, 32'd32);
    @(negedge clk);
    idle();
    chk_wb("b2b_2");
    chk_st("b2b_2", 32'd32, 32'h8, 32'd32);
    @(negedge clk);
    chk("b2b_pulse_end", {31'd0, rd_wr_en}, 32'd0);

    drv(1, mk(10'h000, 5'd9, 5'd17), 32'd0, 0, 1, 1, 1, 32'd9);
    void'(wbq.pop_back());
    @(negedge clk);
    idle();
    n_reset = 1'b0;
    #1;
    chk_st("midrst", 32'd0, 32'h8000_0000, 32'd0);
    chk("midrst_vstart", csr_vstart, 32'd0);
    chk("midrst_wr_en", {31'd0, rd_wr_en}, 32'd0);
    chk("midrst_wdata", rd_wdata, 32'd0);
    chk("midrst_waddr", {27'd0, rd_addr_o}, 32'd0);
    @(negedge clk);
    n_reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_no_wb", {31'd0, rd_wr_en}, 32'd0);
    end
    chk("post_rst_vl", csr_vl, 32'd0);
    chk("wbq_empty", wbq.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vec_csr_regfile.md
Name: vec_csr_regfile

Overview:
- Vector configuration CSR stage, directly downstream of the vector processor controller.
- Consumes the controller's decode strobes (csrwr_en, vl_sel, vtype_sel, rs1rd_de) plus the raw instruction and scalar operands.
- Computes VLMAX and the new vl, then holds the architectural vl, vtype and vstart registers.
- Feeds configuration to the vector datapath and returns the new vl to the scalar rd writeback.

Parameters:
XLEN, 32, scalar register / CSR width
VLEN, 512, vector register length in bits (power of 2, ≥ 64)
ELEN, 32, max element width in bits (8, 16, 32 or 64)

Ports:
clk  input  1  clock
n_reset  input  1  asynchronous active-low reset
inst_valid  input  1  vec_inst and operands valid this cycle
vec_inst  input  XLEN  current vector instruction
rs1_data  input  XLEN  scalar rs1 operand (AVL source)
rs2_data  input  XLEN  scalar rs2 operand (vtype source for vsetvl)
csrwr_en  input  1  controller: configuration write
vl_sel  input  1  controller: 1 = AVL from uimm inst[19:15], 0 = from rs1
vtype_sel  input  1  controller: 1 = vtype from zimm inst[29:20], 0 = from rs2_data
rs1rd_de  input  1  controller: 0 = rs1 and rd both x0 (keep vl)
csr_vl  output  XLEN  current vl
csr_vtype  output  XLEN  current vtype (vill in bit XLEN-1)
csr_vstart  output  XLEN  current vstart
vlmax  output  XLEN  VLMAX for the current vtype (0 when vill)
rd_wr_en  output  1  one-cycle pulse: write rd_wdata to scalar rd
rd_wdata  output  XLEN  new vl for scalar writeback
rd_addr_o  output  5  rd address accompanying rd_wr_en

Behaviour:
- Reset (async, n_reset=0):
  - csr_vl=0, csr_vstart=0, rd_wr_en=0, rd_wdata=0, rd_addr_o=0, vlmax=0.
  - csr_vtype: bit XLEN-1 (vill) = 1, all other bits 0.
  - Reset asserted mid-update discards the pending update.
- Update condition: inst_valid & csrwr_en, sampled on the rising clk edge. No other input changes state.
- vtype candidate:
  - Source: vtype_sel ? zero-extended inst[29:20] : rs2_data.
  - Fields: vlmul=[2:0], vsew=[5:3], vta=[6], vma=[7].
- vill is set if any of the following hold:
  - vlmul==3'b100.
  - SEW=8<<vsew exceeds ELEN.
  - Fractional LMUL (vlmul 5/6/7 = 1/8, 1/4, 1/2) with SEW > ELEN*LMUL.
  - vtype_sel=0 and rs2_data[XLEN-2:8] nonzero.
- VLMAX = (VLEN/SEW) << vlmul for vlmul 0..3, or (VLEN/SEW) >> (8-vlmul) for 5..7. Computed combinationally from the candidate; no divider, shifts only.
- AVL selection:
  - vl_sel=1: zero-extended uimm inst[19:15].
  - vl_sel=0, rs1rd_de=1, inst[19:15]!=0: rs1_data.
  - vl_sel=0, rs1rd_de=1, inst[19:15]==0: all-ones, which forces vl=VLMAX.
  - rs1rd_de=0: AVL = current csr_vl (keep vl).
- New vl = min(AVL, VLMAX), unsigned compare at full XLEN.
- If vill: vtype ← {1, 0...}, vl ← 0, vlmax ← 0. Otherwise vtype ← candidate with bit XLEN-1 cleared.
- vstart ← 0 on every update.
- Writeback: rd_wr_en pulses high for exactly one cycle after the update edge, with rd_wdata = new vl and rd_addr_o = inst[11:7]. It is suppressed when rd=x0.
- Latency: csr_vl, csr_vtype and vlmax reflect the new value on the cycle after the update edge.
- Back-to-back updates are allowed: the second uses the first's result as "current vl" (rs1rd_de=0 case), with no stall.
- Simultaneous inst_valid=0 and csrwr_en=1: no update.

Test Plan:
- Reset: apply n_reset=0 asynchronously → csr_vl=0, csr_vtype=0x8000_0000, csr_vstart=0, rd_wr_en=0 immediately, without waiting for a clock edge.
- vsetvli x6, x5, e32,m1 with rs1_data=100 (vtype_sel=1, vl_sel=0, zimm=0x010) → vlmax=16, csr_vl=16, csr_vtype=0x10; rd_wr_en pulses once with rd_wdata=16, rd_addr_o=6.
- vsetivli x7, 5, e8,m2 (vl_sel=1, uimm=5, zimm=0x001) → vlmax=128, csr_vl=5, rd_wdata=5.
- vsetvl x8, x0, x9 with rs2_data=0x018 (e64>ELEN=32) → vill: csr_vtype=0x8000_0000, csr_vl=0, vlmax=0, rd_wdata=0.
- vsetvli x0, x0, e16,m1 (rs1rd_de=0) after csr_vl=5 → csr_vl stays 5, vtype=0x008, no rd_wr_en (rd=x0).
- Reset mid-stream: update at edge N, n_reset low half a cycle later → all outputs return to reset values, and no rd_wr_en pulse appears after reset release.
